// File: rtl/dmem_pingpong.sv
// N-bank rotating data buffer: producer fills one bank while consumer drains another.
// Latency: write lands on the edge; read data registered, rd_valid one cycle after rd_en.
// Backpressure: wr_ready low when all banks full, rd_avail low when none full; violations set sticky err.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cen                        active-low enable; high freezes all state and suppresses rd_valid
//   wr_en/wr_addr/wr_data      word write into current fill bank (wr_bank)
//   wr_commit                  mark fill bank full, advance fill pointer
//   wr_ready                   a non-full fill bank is available
//   rd_en/rd_addr              word read from current drain bank (rd_bank)
//   rd_release                 mark drain bank empty, advance drain pointer
//   rd_avail                   a full drain bank is available
//   rd_data/rd_valid           registered read data and its one-cycle valid
//   wr_bank/rd_bank/full_cnt   pointer and occupancy status
//   err                        sticky protocol error, cleared only by reset
module dmem_pingpong #(
  parameter int BITS  = 32,
  parameter int ADDR  = 8,
  parameter int NBANK = 2,
  localparam int BW   = (NBANK <= 2) ? 1 : $clog2(NBANK),
  localparam int CW   = $clog2(NBANK + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            wr_en,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            wr_commit,
  output logic            wr_ready,
  input  logic            rd_en,
  input  logic [ADDR-1:0] rd_addr,
  input  logic            rd_release,
  output logic            rd_avail,
  output logic [BITS-1:0] rd_data,
  output logic            rd_valid,
  output logic [BW-1:0]   wr_bank,
  output logic [BW-1:0]   rd_bank,
  output logic [CW-1:0]   full_cnt,
  output logic            err
);

  localparam int DEPTH = 1 << ADDR;

  logic [BITS-1:0] mem [NBANK][DEPTH];

  logic          wr_ok, commit_ok, rd_ok, rel_ok, proto_err;
  logic [CW-1:0] full_cnt_nxt;
  logic [BW-1:0] wr_bank_inc, rd_bank_inc;

  // Legality is judged on the pre-edge count, so a commit at full with a
  // simultaneous release is still rejected while the release goes ahead.
  assign wr_ready  = (full_cnt < CW'(NBANK));
  assign rd_avail  = (full_cnt != '0);

  assign wr_ok     = !cen && wr_en      && wr_ready;
  assign commit_ok = !cen && wr_commit  && wr_ready;
  assign rd_ok     = !cen && rd_en      && rd_avail;
  assign rel_ok    = !cen && rd_release && rd_avail;
  assign proto_err = !cen && (((wr_en || wr_commit) && !wr_ready) ||
                              ((rd_en || rd_release) && !rd_avail));

  assign wr_bank_inc = (wr_bank == BW'(NBANK - 1)) ? '0 : wr_bank + 1'b1;
  assign rd_bank_inc = (rd_bank == BW'(NBANK - 1)) ? '0 : rd_bank + 1'b1;

  always_comb begin
    full_cnt_nxt = full_cnt;
    if (commit_ok && !rel_ok)
      full_cnt_nxt = full_cnt + CW'(1);
    else if (rel_ok && !commit_ok)
      full_cnt_nxt = full_cnt - CW'(1);
  end

  // Storage is not reset. A write alongside a commit uses the pre-edge
  // wr_bank, i.e. it lands in the bank being committed.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_bank][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= '0;
      rd_bank  <= '0;
      full_cnt <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok)
        rd_data <= mem[rd_bank][rd_addr];
      if (commit_ok)
        wr_bank <= wr_bank_inc;
      if (rel_ok)
        rd_bank <= rd_bank_inc;
      full_cnt <= full_cnt_nxt;
      if (proto_err)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_pingpong.sv
// Bench for dmem_pingpong with NBANK=2: vector table of stimulus and expected
// status, read data checked through a scoreboard queue, plus hand sequences
// for the error/enable corner and asynchronous reset with a read pending.
module tb_dmem_pingpong;

  localparam int BITS  = 32;
  localparam int ADDR  = 8;
  localparam int NBANK = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cen = 1'b0;
  logic            wr_en = 1'b0;
  logic [ADDR-1:0] wr_addr = '0;
  logic [BITS-1:0] wr_data = '0;
  logic            wr_commit = 1'b0;
  logic            wr_ready;
  logic            rd_en = 1'b0;
  logic [ADDR-1:0] rd_addr = '0;
  logic            rd_release = 1'b0;
  logic            rd_avail;
  logic [BITS-1:0] rd_data;
  logic            rd_valid;
  logic            wr_bank;
  logic            rd_bank;
  logic [1:0]      full_cnt;
  logic            err;

  dmem_pingpong #(.BITS(BITS), .ADDR(ADDR), .NBANK(NBANK)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
    .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release), .rd_avail(rd_avail),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .full_cnt(full_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cen;
    logic        we;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        wc;
    logic        re;
    logic [7:0]  ra;
    logic        rr;
    logic        rexp_vld;
    logic [31:0] rexp;
    logic [1:0]  fc;
    logic        wb;
    logic        rb;
    logic        er;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] sb[$];
  logic [31:0] last_rd;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic c, input logic we, input logic [7:0] wa, input logic [31:0] wd,
                     input logic wc, input logic re, input logic [7:0] ra, input logic rr,
                     input logic rv, input logic [31:0] rx, input logic [1:0] fc,
                     input logic wb, input logic rb, input logic er);
    vec_t v;
    v.cen = c; v.we = we; v.wa = wa; v.wd = wd; v.wc = wc; v.re = re; v.ra = ra; v.rr = rr;
    v.rexp_vld = rv; v.rexp = rx; v.fc = fc; v.wb = wb; v.rb = rb; v.er = er;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    cen = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [1:0] fc, input logic wb,
                              input logic rb, input logic er);
    chk({tag, ".full_cnt"}, 32'(full_cnt), 32'(fc));
    chk({tag, ".wr_bank"},  32'(wr_bank),  32'(wb));
    chk({tag, ".rd_bank"},  32'(rd_bank),  32'(rb));
    chk({tag, ".err"},      32'(err),      32'(er));
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(fc < 2'd2));
    chk({tag, ".rd_avail"}, 32'(rd_avail), 32'(fc != 2'd0));
  endtask

  // One clock: drive on the falling edge, sample 1ns after the rising edge.
  task automatic apply(input string tag, input vec_t v);
    logic [31:0] exp_d;
    @(negedge clk);
    cen = v.cen; wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; wr_commit = v.wc;
    rd_en = v.re; rd_addr = v.ra; rd_release = v.rr;
    if (v.rexp_vld) sb.push_back(v.rexp);
    @(posedge clk);
    #1;
    check_status(tag, v.fc, v.wb, v.rb, v.er);
    if (sb.size() > 0) begin
      exp_d = sb.pop_front();
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, ".rd_data"}, rd_data, exp_d);
      last_rd = exp_d;
    end else begin
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, ".rd_hold"}, rd_data, last_rd);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    last_rd = '0;
  endtask

  initial begin
    vec_t v;
    last_rd = '0;

    //  cen we wa     wd        wc re ra     rr rv rexp      fc wb rb er
    add(0, 1, 8'd0, 32'hA0, 0, 0, 8'd0, 0, 0, 32'h0,  2'd0, 0, 0, 0);
    add(0, 1, 8'd1, 32'hA1, 0, 0, 8'd0, 0, 0, 32'h0,  2'd0, 0, 0, 0);
    add(0, 1, 8'd2, 32'hA2, 0, 0, 8'd0, 0, 0, 32'h0,  2'd0, 0, 0, 0);
    add(0, 1, 8'd3, 32'hA3, 1, 0, 8'd0, 0, 0, 32'h0,  2'd1, 1, 0, 0); // write+commit
    add(0, 0, 8'd0, 32'h0,  0, 1, 8'd2, 0, 1, 32'hA2, 2'd1, 1, 0, 0); // read latency 1
    add(0, 0, 8'd0, 32'h0,  0, 0, 8'd0, 0, 0, 32'h0,  2'd1, 1, 0, 0); // valid drops, data holds
    add(0, 1, 8'd0, 32'hB0, 0, 0, 8'd0, 0, 0, 32'h0,  2'd1, 1, 0, 0);
    add(0, 0, 8'd0, 32'h0,  1, 0, 8'd0, 0, 0, 32'h0,  2'd2, 0, 0, 0); // all full, wrapped
    add(0, 1, 8'd0, 32'hFF, 1, 0, 8'd0, 0, 0, 32'h0,  2'd2, 0, 0, 1); // illegal write+commit
    add(0, 0, 8'd0, 32'h0,  0, 1, 8'd0, 0, 1, 32'hA0, 2'd2, 0, 0, 1); // no overwrite
    add(0, 0, 8'd0, 32'h0,  0, 1, 8'd1, 1, 1, 32'hA1, 2'd1, 0, 1, 1); // read+release: old bank
    add(0, 0, 8'd0, 32'h0,  1, 1, 8'd0, 1, 1, 32'hB0, 2'd1, 1, 0, 1); // commit+release
    add(0, 0, 8'd0, 32'h0,  1, 1, 8'd3, 1, 1, 32'hA3, 2'd1, 0, 1, 1); // commit+release 1->0/0->1
    add(0, 0, 8'd0, 32'h0,  0, 0, 8'd0, 1, 0, 32'h0,  2'd0, 0, 0, 1); // last release
    add(1, 1, 8'd0, 32'hEE, 1, 1, 8'd0, 0, 0, 32'h0,  2'd0, 0, 0, 1); // cen high: frozen
    add(0, 1, 8'd5, 32'hC5, 1, 0, 8'd0, 0, 0, 32'h0,  2'd1, 1, 0, 1);
    add(0, 0, 8'd0, 32'h0,  0, 1, 8'd5, 0, 1, 32'hC5, 2'd1, 1, 0, 1);
    add(0, 0, 8'd0, 32'h0,  0, 1, 8'd0, 0, 1, 32'hA0, 2'd1, 1, 0, 1); // cen write dropped

    do_reset();
    #1;
    check_status("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.rd_valid", 32'(rd_valid), 32'd0);
    chk("reset.rd_data", rd_data, 32'h0);

    for (int i = 0; i < vq.size(); i++)
      apply($sformatf("vec%0d", i), vq[i]);

    // Release with nothing full, then a fully frozen cycle with cen high.
    do_reset();
    v = '{0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 1, 0, 32'h0, 2'd0, 0, 0, 1};
    apply("rel_empty", v);
    v = '{1, 1, 8'd1, 32'h11, 1, 1, 8'd0, 1, 0, 32'h0, 2'd0, 0, 0, 1};
    apply("cen_hold", v);

    // Fill both banks, then reset asynchronously with a read request pending.
    v = '{0, 1, 8'd0, 32'hD0, 1, 0, 8'd0, 0, 0, 32'h0, 2'd1, 1, 0, 1};
    apply("fill0", v);
    v = '{0, 1, 8'd0, 32'hD1, 1, 0, 8'd0, 0, 0, 32'h0, 2'd2, 0, 0, 1};
    apply("fill1", v);
    @(negedge clk);
    idle_inputs();
    rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_status("arst", 2'd0, 1'b0, 1'b0, 1'b0);
    chk("arst.rd_valid", 32'(rd_valid), 32'd0);
    chk("arst.rd_data", rd_data, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_edge.rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    sb.delete();
    last_rd = '0;
    v = '{0, 0, 8'd0, 32'h0, 0, 0, 8'd0, 0, 0, 32'h0, 2'd0, 0, 0, 0};
    apply("post_arst", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_pingpong.md
Name: dmem_pingpong

Overview:
- Parametrised N-bank rotating data buffer for the PE datapath.
- Generalises the fixed two-bank ping-pong data memory: NBANK banks with independent producer and consumer ports.
- A producer fills one bank while a consumer drains another; explicit commit/release handshakes rotate bank ownership.
- Adds per-bank full tracking, registered read with valid, and a sticky protocol-error flag.

Parameters:
- BITS, 32, data word width.
- ADDR, 8, word address width per bank; DEPTH = 2**ADDR words per bank.
- NBANK, 2, number of banks, legal range 2..8.
- Derived: BW = max(1, $clog2(NBANK)) bank index width; CW = $clog2(NBANK+1) count width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cen  input  1  active-low global enable; when 1, all requests are ignored and state holds.
- wr_en  input  1  write word into current fill bank.
- wr_addr  input  ADDR  write word address.
- wr_data  input  BITS  write data.
- wr_commit  input  1  mark fill bank full and advance the fill pointer.
- wr_ready  output  1  a non-full fill bank is available.
- rd_en  input  1  read word from current drain bank.
- rd_addr  input  ADDR  read word address.
- rd_release  input  1  mark drain bank empty and advance the drain pointer.
- rd_avail  output  1  a full drain bank is available.
- rd_data  output  BITS  registered read data.
- rd_valid  output  1  rd_data updated this cycle.
- wr_bank  output  BW  current fill bank index.
- rd_bank  output  BW  current drain bank index.
- full_cnt  output  CW  number of full banks.
- err  output  1  sticky protocol error.

Behaviour:
- Storage: NBANK x DEPTH x BITS behavioural array. Contents are not reset.
- Reset (async assert, sync release) clears:
  - wr_bank = 0, rd_bank = 0, full_cnt = 0.
  - rd_data = 0, rd_valid = 0, err = 0.
  - Resulting outputs: wr_ready = 1, rd_avail = 0.
- Combinational outputs: wr_ready = (full_cnt < NBANK); rd_avail = (full_cnt > 0).
- All rules below apply only when cen = 0. When cen = 1: no array access, pointers/count/rd_data/err hold, rd_valid = 0 next cycle.
- Write:
  - wr_en & wr_ready stores wr_data at [wr_bank][wr_addr] on the edge.
  - wr_en & !wr_ready: dropped, err <= 1.
- Commit:
  - wr_commit & wr_ready: wr_bank <= (wr_bank == NBANK-1) ? 0 : wr_bank+1, and full_cnt increments.
  - A write in the same cycle as a commit lands in the committing (old) bank.
  - wr_commit & !wr_ready: ignored, err <= 1.
- Read:
  - rd_en & rd_avail: rd_data <= [rd_bank][rd_addr]; rd_valid = 1 the next cycle (latency 1).
  - Otherwise rd_data holds and rd_valid = 0.
  - rd_en & !rd_avail: no read, err <= 1.
- Release:
  - rd_release & rd_avail: rd_bank advances with wrap, and full_cnt decrements.
  - A read in the same cycle as a release reads the releasing (old) bank.
  - rd_release & !rd_avail: ignored, err <= 1.
- Commit and release in the same cycle, both legal: full_cnt unchanged, both pointers advance.
- Commit legality is judged on pre-edge full_cnt. A commit at full_cnt == NBANK together with a release is an error and is ignored; the release proceeds.
- Bank conflicts are impossible by construction:
  - wr_bank == rd_bank only when full_cnt is 0 or NBANK.
  - At those counts either reads or writes are disallowed.
- err clears only on reset.
- Reset mid-operation: all status returns to reset values immediately; pending rd_valid is cancelled.

Test Plan:
- Reset with NBANK = 2 -> wr_ready = 1, rd_avail = 0, full_cnt = 0, wr_bank = 0, rd_bank = 0, err = 0.
- Write 0xA0..0xA3 to addr 0..3 with commit on the last write; rd_en at addr 2 -> next cycle rd_data = 0xA2, rd_valid = 1; cycle after that rd_valid = 0, rd_data holds 0xA2.
- Commit two banks -> full_cnt = 2, wr_ready = 0, wr_bank = 0 (wrapped); then write 0xFF to addr 0 with commit -> err = 1, full_cnt = 2, bank0 addr 0 still reads 0xA0.
- With full_cnt = 1, assert wr_commit and rd_release in the same cycle -> full_cnt = 1, wr_bank 1->0, rd_bank 0->1.
- Cycle 1: rd_release at full_cnt = 0 -> err = 1, rd_bank unchanged. Cycle 2: cen = 1 with wr_en, wr_commit, rd_en -> no change to any state, rd_valid = 0.
- Assert rst_n = 0 asynchronously mid-cycle at full_cnt = 2 with a read pending -> outputs reset immediately; after release rd_avail = 0, rd_valid = 0, err = 0.
